// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage:
// load/store type codes, FSM states, bus and MEM/WB bundles.
package mem_access_stage_pkg;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  localparam logic [1:0] ST_SB  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SW  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [1:0]  lane;
    logic [2:0]  ltype;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] load_data;
    logic [4:0]  rd;
    logic        wb_reg_file;
    logic        memtoreg;
    logic        valid;
  } mem_wb_t;

  // Byte lanes pass; halfwords keep lane[1]; words use lane 0.
  function automatic logic [1:0] align_lane(
    logic [1:0] lane,
    logic       is_byte,
    logic       is_half
  );
    logic [1:0] r;
    r = 2'b00;
    unique case (1'b1)
      is_byte: r = lane;
      is_half: r = {lane[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align_unit: shifts the read word down to the
// addressed lane, then sign- or zero-extends.
module load_align_unit
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [31:0] sh;

  // Lane shift followed by width-specific extension.
  always_comb begin
    sh = rdata >> {lane, 3'b000};
    unique case (load_type)
      LT_LB:   data = {{24{sh[7]}}, sh[7:0]};
      LT_LH:   data = {{16{sh[15]}}, sh[15:0]};
      LT_LBU:  data = {24'h0, sh[7:0]};
      LT_LHU:  data = {16'h0, sh[15:0]};
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM to MEM/WB stage with data-bus FSM.
// Define MISALIGN_TRAP_EN to trap misaligned SH/SW stores.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] rs2_data_mem,
  input  logic [4:0]  rd_mem,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  mem_load_type_mem,
  input  logic [1:0]  mem_store_type_mem,
  input  logic        wb_reg_file_mem,
  input  logic        memtoreg_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] alu_result_wb,
  output logic [31:0] load_data_wb,
  output logic [4:0]  rd_wb,
  output logic        wb_reg_file_wb,
  output logic        memtoreg_wb,
  output logic        valid_wb,
  output logic [31:0] data_forward_mem,
  output logic        bus_err,
  output logic        misalign_exc
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bus_req_t      req_q, req_d, new_req;
  logic          dmem_req_q, dmem_req_d;
  logic          bus_err_q, bus_err_d;
  mem_wb_t       wb_q, wb_d;

  logic          access;
  logic          trap;
  logic          trap_now;
  logic          complete;
  logic          timeout;
  logic          st_byte, st_half;
  logic          is_byte, is_half;
  logic [1:0]    lane;
  logic [31:0]   ld_data;

  assign access = valid_mem & (mem_read_mem | mem_write_mem);

  assign st_byte = mem_store_type_mem == ST_SB;
  assign st_half = mem_store_type_mem == ST_SH;

  // Access width decides which low address bits survive.
  always_comb begin
    if (mem_write_mem) begin
      is_byte = st_byte;
      is_half = st_half;
    end else begin
      is_byte = (mem_load_type_mem == LT_LB) |
                (mem_load_type_mem == LT_LBU);
      is_half = (mem_load_type_mem == LT_LH) |
                (mem_load_type_mem == LT_LHU);
    end
    lane = align_lane(alu_result_mem[1:0], is_byte, is_half);
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = mem_write_mem &
                      ((st_half & alu_result_mem[0]) |
                       (~st_byte & ~st_half & |alu_result_mem[1:0]));
  assign trap = access & misaligned;
`else
  assign trap = 1'b0;
`endif

  assign trap_now = (state_q == S_IDLE) & trap;
  assign misalign_exc = rst_n & trap_now;

  // Bus request captured on REQ entry: lane enables and replication.
  always_comb begin
    new_req       = '0;
    new_req.addr  = {alu_result_mem[31:2], 2'b00};
    new_req.we    = mem_write_mem;
    new_req.lane  = lane;
    new_req.ltype = mem_load_type_mem;
    new_req.be    = 4'b1111;
    new_req.wdata = rs2_data_mem;
    if (mem_write_mem) begin
      unique case (1'b1)
        st_byte: begin
          new_req.be    = 4'b0001 << lane;
          new_req.wdata = {4{rs2_data_mem[7:0]}};
        end
        st_half: begin
          new_req.be    = 4'b0011 << lane;
          new_req.wdata = {2{rs2_data_mem[15:0]}};
        end
        default: ;
      endcase
    end
  end

  assign complete = ((state_q == S_REQ) & dmem_gnt & req_q.we) |
                    ((state_q == S_WAIT) & dmem_rvalid);

  assign timeout = (state_q != S_IDLE) &
                   (cnt_q == CW'(DMEM_TIMEOUT - 1)) & ~complete;

  assign mem_stall = ~timeout &
    (((state_q == S_IDLE) & access & ~trap) |
     ((state_q == S_REQ) & ~(dmem_gnt & req_q.we)) |
     ((state_q == S_WAIT) & ~dmem_rvalid));

  // Bus FSM: issue, wait for grant / read data, abandon on timeout.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    dmem_req_d = dmem_req_q;
    bus_err_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access & ~trap) begin
          state_d    = S_REQ;
          cnt_d      = '0;
          req_d      = new_req;
          dmem_req_d = 1'b1;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout) begin
          state_d    = S_IDLE;
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
        end else if (dmem_gnt) begin
          state_d    = req_q.we ? S_IDLE : S_WAIT;
          dmem_req_d = 1'b0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (timeout) begin
          state_d   = S_IDLE;
          bus_err_d = 1'b1;
        end else if (dmem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  load_align_unit u_align (
    .rdata     (dmem_rdata),
    .lane      (req_q.lane),
    .load_type (req_q.ltype),
    .data      (ld_data)
  );

  // MEM/WB: advance when not stalled, bubble while stalled.
  always_comb begin
    wb_d             = wb_q;
    wb_d.valid       = 1'b0;
    wb_d.wb_reg_file = 1'b0;
    if (!mem_stall) begin
      wb_d.valid       = valid_mem & ~trap_now & ~timeout;
      wb_d.wb_reg_file = wb_reg_file_mem & valid_mem &
                         ~trap_now & ~timeout;
      wb_d.alu_result  = alu_result_mem;
      wb_d.load_data   = ld_data;
      wb_d.rd          = rd_mem;
      wb_d.memtoreg    = memtoreg_mem;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      dmem_req_q <= 1'b0;
      bus_err_q  <= 1'b0;
      wb_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dmem_req_q <= dmem_req_d;
      bus_err_q  <= bus_err_d;
      wb_q       <= wb_d;
    end
  end

  assign dmem_req         = dmem_req_q;
  assign dmem_we          = req_q.we;
  assign dmem_addr        = req_q.addr;
  assign dmem_wdata       = req_q.wdata;
  assign dmem_be          = req_q.be;
  assign bus_err          = bus_err_q;
  assign data_forward_mem = alu_result_mem;
  assign alu_result_wb    = wb_q.alu_result;
  assign load_data_wb     = wb_q.load_data;
  assign rd_wb            = wb_q.rd;
  assign wb_reg_file_wb   = wb_q.wb_reg_file;
  assign memtoreg_wb      = wb_q.memtoreg;
  assign valid_wb         = wb_q.valid;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: randomized loads/stores
// against a byte-level reference model, plus directed cases.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] rs2_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_write_mem;
  logic        mem_read_mem;
  logic [2:0]  mem_load_type_mem;
  logic [1:0]  mem_store_type_mem;
  logic        wb_reg_file_mem;
  logic        memtoreg_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] alu_result_wb;
  logic [31:0] load_data_wb;
  logic [4:0]  rd_wb;
  logic        wb_reg_file_wb;
  logic        memtoreg_wb;
  logic        valid_wb;
  logic [31:0] data_forward_mem;
  logic        bus_err;
  logic        misalign_exc;

  int tests = 0;
  int fails = 0;

  int          r_stall;
  int          r_extra_wb;
  int          r_req_n;
  int          r_mis;
  logic        r_hang;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;

  always #5 clk = ~clk;

  mem_access_stage #(.DMEM_TIMEOUT(255)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .valid_mem          (valid_mem),
    .alu_result_mem     (alu_result_mem),
    .rs2_data_mem       (rs2_data_mem),
    .rd_mem             (rd_mem),
    .mem_write_mem      (mem_write_mem),
    .mem_read_mem       (mem_read_mem),
    .mem_load_type_mem  (mem_load_type_mem),
    .mem_store_type_mem (mem_store_type_mem),
    .wb_reg_file_mem    (wb_reg_file_mem),
    .memtoreg_mem       (memtoreg_mem),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_gnt           (dmem_gnt),
    .dmem_rvalid        (dmem_rvalid),
    .dmem_rdata         (dmem_rdata),
    .mem_stall          (mem_stall),
    .alu_result_wb      (alu_result_wb),
    .load_data_wb       (load_data_wb),
    .rd_wb              (rd_wb),
    .wb_reg_file_wb     (wb_reg_file_wb),
    .memtoreg_wb        (memtoreg_wb),
    .valid_wb           (valid_wb),
    .data_forward_mem   (data_forward_mem),
    .bus_err            (bus_err),
    .misalign_exc       (misalign_exc)
  );

  // ---- reference model ----
  function automatic int acc_size(bit is_st, logic [2:0] lt,
                                  logic [1:0] stt);
    if (is_st) return (stt == 2'd0) ? 1 : (stt == 2'd1) ? 2 : 4;
    if (lt == 3'd0 || lt == 3'd3) return 1;
    if (lt == 3'd1 || lt == 3'd4) return 2;
    return 4;
  endfunction

  function automatic int acc_off(logic [31:0] addr, int size);
    int o;
    o = int'(addr % 4);
    return o - (o % size);
  endfunction

  function automatic logic [3:0] model_be(int off, int size);
    logic [3:0] m;
    m = 4'b0;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + size) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] d, int size);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++)
      w = w | (((d >> (8 * (i % size))) & 32'hFF) << (8 * i));
    return w;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] rd,
      logic [2:0] lt, int off, int size);
    longint v;
    v = 0;
    for (int k = 0; k < size; k++)
      v = v + (longint'((rd >> (8 * (off + k))) & 32'hFF) << (8 * k));
    if ((lt == 3'd0 || lt == 3'd1) &&
        v >= (longint'(1) << (8 * size - 1)))
      v = v - (longint'(1) << (8 * size));
    return v[31:0];
  endfunction

  // ---- stimulus helpers ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_mem     = 1'b0;
    mem_write_mem = 1'b0;
    mem_read_mem  = 1'b0;
    dmem_gnt      = 1'b0;
    dmem_rvalid   = 1'b0;
  endtask

  // Present one instruction and act as the bus slave until it retires.
  task automatic run_access(input bit is_st, input bit is_ld,
      input logic [2:0] lt, input logic [1:0] stt,
      input logic [31:0] addr, input logic [31:0] data,
      input logic [31:0] rdata, input int gdly, input int rdly,
      input logic [4:0] rd);
    bit granted;
    int w;
    valid_mem          = 1'b1;
    mem_write_mem      = is_st;
    mem_read_mem       = is_ld;
    mem_load_type_mem  = lt;
    mem_store_type_mem = stt;
    alu_result_mem     = addr;
    rs2_data_mem       = data;
    rd_mem             = rd;
    wb_reg_file_mem    = ~is_st;
    memtoreg_mem       = is_ld;
    r_stall = 0; r_extra_wb = 0; r_req_n = 0; r_mis = 0;
    r_hang = 1'b1; r_addr = '0; r_wdata = '0; r_be = '0; r_we = 1'b0;
    granted = 1'b0;
    w = 0;
    for (int c = 0; c < 600; c++) begin
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
      if (dmem_req) begin
        if (r_req_n == 0) begin
          r_addr = dmem_addr; r_wdata = dmem_wdata;
          r_be = dmem_be; r_we = dmem_we;
        end
        if (r_req_n == gdly) dmem_gnt = 1'b1;
        r_req_n++;
      end else if (granted) begin
        if (w == rdly - 1) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdata;
        end
        w++;
      end
      #1;
      if (misalign_exc) r_mis++;
      if (c > 0 && valid_wb) r_extra_wb++;
      if (dmem_gnt) granted = 1'b1;
      if (!mem_stall) begin
        r_hang = 1'b0;
        step();
        break;
      end
      r_stall++;
      step();
    end
    idle_inputs();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    tests++; if (dmem_req !== 1'b0) begin fails++;
      $display("FAIL reset_req got=%b exp=0", dmem_req); end
    tests++; if (valid_wb !== 1'b0 || wb_reg_file_wb !== 1'b0) begin
      fails++; $display("FAIL reset_wb got=%b%b exp=00",
                        valid_wb, wb_reg_file_wb); end
    tests++; if ({alu_result_wb, load_data_wb, rd_wb, memtoreg_wb}
                 !== '0) begin fails++;
      $display("FAIL reset_wbdata got=%h/%h/%h/%b exp=0",
               alu_result_wb, load_data_wb, rd_wb, memtoreg_wb); end
    tests++; if (bus_err !== 1'b0 || misalign_exc !== 1'b0 ||
                 mem_stall !== 1'b0) begin fails++;
      $display("FAIL reset_flags got=%b%b%b exp=000",
               bus_err, misalign_exc, mem_stall); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_non_access();
    logic [31:0] a;
    logic [4:0]  r;
    logic        wbf;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; r = 5'($urandom); wbf = 1'($urandom);
      valid_mem = 1'b1; mem_write_mem = 1'b0; mem_read_mem = 1'b0;
      alu_result_mem = a; rd_mem = r; wb_reg_file_mem = wbf;
      memtoreg_mem = 1'b0;
      #1;
      tests++; if (mem_stall !== 1'b0 || data_forward_mem !== a) begin
        fails++; $display("FAIL alu_comb stall=%b fwd=%h exp=0/%h",
                          mem_stall, data_forward_mem, a); end
      step();
      tests++; if (valid_wb !== 1'b1 || alu_result_wb !== a ||
                   rd_wb !== r || wb_reg_file_wb !== wbf) begin
        fails++; $display("FAIL alu_wb got=%b/%h/%h/%b exp=1/%h/%h/%b",
          valid_wb, alu_result_wb, rd_wb, wb_reg_file_wb, a, r, wbf); end
    end
    idle_inputs();
    step();
    tests++; if (valid_wb !== 1'b0 || wb_reg_file_wb !== 1'b0) begin
      fails++; $display("FAIL bubble_wb got=%b%b exp=00",
                        valid_wb, wb_reg_file_wb); end
  endtask

  task automatic test_sw_directed();
    run_access(1, 0, 3'd0, 2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 2, 1, 5'd0);
    tests++; if (r_be !== 4'b1111 || r_wdata !== 32'hDEADBEEF ||
                 r_addr !== 32'h100 || r_we !== 1'b1) begin fails++;
      $display("FAIL sw_bus got=%b/%h/%h/%b exp=1111/deadbeef/100/1",
               r_be, r_wdata, r_addr, r_we); end
    tests++; if (r_stall !== 3) begin fails++;
      $display("FAIL sw_stall got=%0d exp=3", r_stall); end
    tests++; if (valid_wb !== 1'b1 || r_extra_wb !== 0) begin fails++;
      $display("FAIL sw_wb got=%b extra=%0d exp=1/0",
               valid_wb, r_extra_wb); end
    step();
    tests++; if (valid_wb !== 1'b0) begin fails++;
      $display("FAIL sw_wb_once got=%b exp=0", valid_wb); end
  endtask

  task automatic test_lb_directed();
    run_access(0, 1, 3'd0, 2'd0, 32'h203, 32'h0, 32'h80FF0000, 0, 1, 5'd3);
    tests++; if (load_data_wb !== 32'hFFFFFF80 || valid_wb !== 1'b1)
      begin fails++; $display("FAIL lb_data got=%h/%b exp=ffffff80/1",
                              load_data_wb, valid_wb); end
    tests++; if (r_stall !== 2) begin fails++;
      $display("FAIL lb_stall got=%0d exp=2", r_stall); end
    run_access(0, 1, 3'd3, 2'd0, 32'h203, 32'h0, 32'h80FF0000, 1, 2, 5'd4);
    tests++; if (load_data_wb !== 32'h00000080) begin fails++;
      $display("FAIL lbu_data got=%h exp=00000080", load_data_wb); end
  endtask

  task automatic test_sh_directed();
    run_access(1, 0, 3'd0, 2'd1, 32'h102, 32'h1234, 32'h0, 0, 1, 5'd0);
    tests++; if (r_be !== 4'b1100 || r_wdata !== 32'h12341234) begin
      fails++; $display("FAIL sh_bus got=%b/%h exp=1100/12341234",
                        r_be, r_wdata); end
    tests++; if (r_stall !== 1) begin fails++;
      $display("FAIL sh_stall got=%0d exp=1", r_stall); end
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign();
    run_access(1, 0, 3'd0, 2'd2, 32'h101, 32'h55AA55AA, 32'h0, 0, 1, 5'd0);
    tests++; if (r_mis !== 1 || r_req_n !== 0 || r_stall !== 0) begin
      fails++; $display("FAIL mis_trap got=%0d/%0d/%0d exp=1/0/0",
                        r_mis, r_req_n, r_stall); end
    tests++; if (valid_wb !== 1'b0 || misalign_exc !== 1'b0 ||
                 dmem_req !== 1'b0) begin fails++;
      $display("FAIL mis_after got=%b%b%b exp=000",
               valid_wb, misalign_exc, dmem_req); end
  endtask
`else
  task automatic test_misalign();
    run_access(1, 0, 3'd0, 2'd2, 32'h101, 32'h55AA1234, 32'h0, 0, 1, 5'd0);
    tests++; if (r_be !== 4'b1111 || r_addr !== 32'h100 ||
                 r_wdata !== 32'h55AA1234 || r_mis !== 0) begin fails++;
      $display("FAIL sw_trunc got=%b/%h/%h/%0d exp=1111/100/55aa1234/0",
               r_be, r_addr, r_wdata, r_mis); end
    run_access(0, 1, 3'd1, 2'd0, 32'h101, 32'h0, 32'h12348001, 0, 1, 5'd2);
    tests++; if (load_data_wb !== 32'hFFFF8001) begin fails++;
      $display("FAIL lh_trunc got=%h exp=ffff8001", load_data_wb); end
  endtask
`endif

  task automatic test_random_mem();
    bit          is_st;
    logic [2:0]  lt;
    logic [1:0]  stt;
    logic [31:0] addr, data, rdat;
    logic [4:0]  rd;
    int          g, rv, sz, off, exp_stall;
    for (int n = 0; n < 40; n++) begin
      is_st = 1'($urandom);
      lt    = 3'($urandom);
      stt   = 2'($urandom);
      addr  = $urandom;
      data  = $urandom;
      rdat  = $urandom;
      rd    = 5'($urandom);
      g     = $urandom_range(0, 3);
      rv    = $urandom_range(1, 3);
      sz    = acc_size(is_st, lt, stt);
`ifdef MISALIGN_TRAP_EN
      if (is_st) addr = addr & ~(32'(sz) - 1);
`endif
      off = acc_off(addr, sz);
      exp_stall = is_st ? 1 + g : 1 + g + rv;
      run_access(is_st, ~is_st, lt, stt, addr, data, rdat, g, rv, rd);
      tests++; if (r_hang !== 1'b0 || r_stall !== exp_stall) begin
        fails++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d hang=%b",
                          n, r_stall, exp_stall, r_hang); end
      tests++; if (r_addr !== {addr[31:2], 2'b00} || r_we !== is_st)
        begin fails++; $display("FAIL rnd_addr n=%0d got=%h/%b exp=%h/%b",
          n, r_addr, r_we, {addr[31:2], 2'b00}, is_st); end
      tests++; if (valid_wb !== 1'b1 || rd_wb !== rd ||
                   r_extra_wb !== 0) begin fails++;
        $display("FAIL rnd_wb n=%0d got=%b/%h/%0d exp=1/%h/0",
                 n, valid_wb, rd_wb, r_extra_wb, rd); end
      if (is_st) begin
        tests++; if (r_be !== model_be(off, sz) ||
                     r_wdata !== model_wdata(data, sz)) begin fails++;
          $display("FAIL rnd_store n=%0d got=%b/%h exp=%b/%h", n,
                   r_be, r_wdata, model_be(off, sz),
                   model_wdata(data, sz)); end
      end else begin
        tests++; if (load_data_wb !== model_load(rdat, lt, off, sz))
          begin fails++; $display("FAIL rnd_load n=%0d got=%h exp=%h",
            n, load_data_wb, model_load(rdat, lt, off, sz)); end
      end
    end
  endtask

  task automatic test_timeout();
    run_access(0, 1, 3'd2, 2'd0, 32'h300, 32'h0, 32'h0, 0, 1000000, 5'd9);
    tests++; if (r_hang !== 1'b0 || r_stall !== 255) begin fails++;
      $display("FAIL to_stall got=%0d hang=%b exp=255/0",
               r_stall, r_hang); end
    tests++; if (bus_err !== 1'b1 || valid_wb !== 1'b0 ||
                 wb_reg_file_wb !== 1'b0) begin fails++;
      $display("FAIL to_retire got=%b/%b/%b exp=1/0/0",
               bus_err, valid_wb, wb_reg_file_wb); end
    step();
    tests++; if (bus_err !== 1'b0 || mem_stall !== 1'b0 ||
                 dmem_req !== 1'b0) begin fails++;
      $display("FAIL to_after got=%b%b%b exp=000",
               bus_err, mem_stall, dmem_req); end
  endtask

  task automatic test_reset_mid_access();
    valid_mem = 1'b1; mem_read_mem = 1'b1; mem_write_mem = 1'b0;
    mem_load_type_mem = 3'd2; alu_result_mem = 32'h40;
    rd_mem = 5'd7; wb_reg_file_mem = 1'b1; memtoreg_mem = 1'b1;
    step();
    dmem_gnt = dmem_req;
    step();
    dmem_gnt = 1'b0;
    step();
    tests++; if (mem_stall !== 1'b1 || dmem_req !== 1'b0) begin fails++;
      $display("FAIL rst_wait got=%b%b exp=10", mem_stall, dmem_req); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (dmem_req !== 1'b0 || valid_wb !== 1'b0) begin fails++;
      $display("FAIL rst_async got=%b%b exp=00", dmem_req, valid_wb); end
    idle_inputs();
    step();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    #1;
    tests++; if (mem_stall !== 1'b0) begin fails++;
      $display("FAIL late_rv_stall got=%b exp=0", mem_stall); end
    step();
    dmem_rvalid = 1'b0;
    tests++; if (valid_wb !== 1'b0 || wb_reg_file_wb !== 1'b0 ||
                 dmem_req !== 1'b0) begin fails++;
      $display("FAIL late_rv_wb got=%b%b%b exp=000",
               valid_wb, wb_reg_file_wb, dmem_req); end
    run_access(0, 1, 3'd4, 2'd0, 32'h42, 32'h0, 32'hBEEF0000, 0, 1, 5'd8);
    tests++; if (load_data_wb !== 32'h0000BEEF || valid_wb !== 1'b1)
      begin fails++; $display("FAIL post_rst_lhu got=%h/%b exp=0000beef/1",
                              load_data_wb, valid_wb); end
  endtask

  initial begin
    rst_n = 1'b0;
    alu_result_mem = '0; rs2_data_mem = '0; rd_mem = '0;
    mem_load_type_mem = '0; mem_store_type_mem = '0;
    wb_reg_file_mem = 1'b0; memtoreg_mem = 1'b0;
    dmem_rdata = '0;
    idle_inputs();
    test_reset();
    test_non_access();
    test_sw_directed();
    test_lb_directed();
    test_sh_directed();
    test_misalign();
    test_random_mem();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
